// File: rtl/h2k_particle_scatter.sv
// rtl/h2k_particle_scatter.sv - unpacks 4-lane host beats into per-cell position records
// Optional MD_SCATTER_TDEST_FILTER_EN: beats whose tdest differs from i_init_id are dropped whole.
module h2k_particle_scatter #(
  parameter int AXIS_TDATA_WIDTH      = 512,
  parameter int STREAMING_TDEST_WIDTH = 16,
  parameter int N_CELL                = 27,
  parameter int POS_WIDTH             = 96
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             i_enable,
  input  logic [STREAMING_TDEST_WIDTH-1:0] i_init_id,
  input  logic [AXIS_TDATA_WIDTH-1:0]      S_AXIS_h2k_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0]    S_AXIS_h2k_tkeep,
  input  logic                             S_AXIS_h2k_tvalid,
  input  logic                             S_AXIS_h2k_tlast,
  input  logic [STREAMING_TDEST_WIDTH-1:0] S_AXIS_h2k_tdest,
  output logic                             S_AXIS_h2k_tready,
  output logic [POS_WIDTH-1:0]             o_cell_data,
  output logic [N_CELL-1:0]                o_cell_en,
  input  logic [N_CELL-1:0]                i_cell_ready,
  output logic                             o_frame_done,
  output logic [31:0]                      o_rec_count,
  output logic [31:0]                      o_drop_count
);
  localparam int LANES  = 4;
  localparam int LANE_W = 128;
  localparam int REC_W  = POS_WIDTH + 5;

  typedef enum logic {S_IDLE = 1'b0, S_UNPACK = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [LANES-1:0][REC_W-1:0] rec_q, rec_d;
  logic [LANES-1:0]            mask_q, mask_d, in_mask, mask_clr;
  logic                        last_q, last_d, drop_all_q, drop_all_d;
  logic                        frame_done_q, frame_done_d;
  logic [31:0]                 rec_cnt_q, rec_cnt_d, drop_cnt_q, drop_cnt_d;
  logic                        accept, tdest_miss, busy, deliver, ready_hit, lane_done;
  logic [1:0]                  sel;
  logic [REC_W-1:0]            sel_rec;
  logic [31:0]                 sel_id;
  logic                        unused_bits;

  assign S_AXIS_h2k_tready = (state_q == S_IDLE) && i_enable && ap_rst_n;
  assign accept            = S_AXIS_h2k_tvalid && S_AXIS_h2k_tready;

  // A lane counts only when all 16 of its bytes are kept and its record-valid bit is set.
  always_comb begin
    in_mask     = '0;
    unused_bits = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      in_mask[k]  = (&S_AXIS_h2k_tkeep[16*k +: 16]) && S_AXIS_h2k_tdata[LANE_W*k + LANE_W - 1];
      unused_bits = unused_bits ^ (^S_AXIS_h2k_tdata[LANE_W*k + REC_W +: LANE_W - 1 - REC_W]);
    end
  end

`ifdef MD_SCATTER_TDEST_FILTER_EN
  assign tdest_miss = (S_AXIS_h2k_tdest != i_init_id);
`else
  logic unused_tdest;
  assign tdest_miss   = 1'b0;
  assign unused_tdest = ^{S_AXIS_h2k_tdest, i_init_id};
`endif

  always_comb begin
    sel = 2'd0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (mask_q[k]) sel = 2'(k);
    end
  end

  assign sel_rec   = rec_q[sel];
  assign sel_id    = 32'(sel_rec[POS_WIDTH +: 5]);
  assign busy      = (state_q == S_UNPACK) && (mask_q != '0);
  assign deliver   = busy && !drop_all_q && (sel_id < 32'(N_CELL));
  assign mask_clr  = mask_q & ~(LANES'(1) << sel);
  assign ready_hit = |(i_cell_ready & o_cell_en);
  assign lane_done = busy && (!deliver || ready_hit);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept && (in_mask != '0)) state_d = S_UNPACK;
      S_UNPACK: if (!busy || (lane_done && (mask_clr == '0))) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_cell_en   = '0;
    o_cell_data = '0;
    if (deliver) begin
      o_cell_data = sel_rec[POS_WIDTH-1:0];
      for (int c = 0; c < N_CELL; c++) o_cell_en[c] = (sel_id == 32'(c));
    end
  end

  // accept only happens in IDLE and lane_done only in UNPACK, so the branches never overlap.
  always_comb begin
    rec_d        = rec_q;
    mask_d       = mask_q;
    last_d       = last_q;
    drop_all_d   = drop_all_q;
    rec_cnt_d    = rec_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    frame_done_d = 1'b0;
    if (accept) begin
      for (int k = 0; k < LANES; k++) rec_d[k] = S_AXIS_h2k_tdata[LANE_W*k +: REC_W];
      mask_d       = in_mask;
      last_d       = S_AXIS_h2k_tlast;
      drop_all_d   = tdest_miss;
      frame_done_d = S_AXIS_h2k_tlast && (in_mask == '0);
    end else if (lane_done) begin
      mask_d       = mask_clr;
      frame_done_d = last_q && (mask_clr == '0);
      if (deliver) begin
        if (rec_cnt_q != '1) rec_cnt_d = rec_cnt_q + 32'd1;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      mask_q       <= '0;
      last_q       <= 1'b0;
      drop_all_q   <= 1'b0;
      frame_done_q <= 1'b0;
      rec_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      mask_q       <= mask_d;
      last_q       <= last_d;
      drop_all_q   <= drop_all_d;
      frame_done_q <= frame_done_d;
      rec_cnt_q    <= rec_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    rec_q <= rec_d;
  end

  assign o_frame_done = frame_done_q;
  assign o_rec_count  = rec_cnt_q;
  assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_h2k_particle_scatter.sv
// tb/tb_h2k_particle_scatter.sv - directed bench with a record-queue model of the scatter block
module tb_h2k_particle_scatter;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n, en, tvalid, tlast, tready, fd;
  logic [15:0]  init_id, tdest;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic [95:0]  cell_data;
  logic [26:0]  cell_en, cell_ready;
  logic [31:0]  rec_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  h2k_particle_scatter dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .i_enable(en), .i_init_id(init_id),
    .S_AXIS_h2k_tdata(tdata), .S_AXIS_h2k_tkeep(tkeep), .S_AXIS_h2k_tvalid(tvalid),
    .S_AXIS_h2k_tlast(tlast), .S_AXIS_h2k_tdest(tdest), .S_AXIS_h2k_tready(tready),
    .o_cell_data(cell_data), .o_cell_en(cell_en), .i_cell_ready(cell_ready),
    .o_frame_done(fd), .o_rec_count(rec_cnt), .o_drop_count(drop_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each accepted beat becomes an ordered list of records; the head record is what
  // the outputs must show this cycle, and it retires on a drop or on a ready handshake.
  typedef struct {bit drop; int id; logic [95:0] pay; bit fd;} mrec_t;
  mrec_t mq[$];
  int    m_rec  = 0;
  int    m_drop = 0;
  bit    fd_flag = 1'b0;

  always @(negedge clk) begin
    mrec_t       h;
    mrec_t       recs [4];
    int          n;
    bit          exp_ready, filt;
    logic [26:0] e;
    if (!rst_n) begin
      chk("tready_in_reset", tready, 1'b0);
      mq.delete();
      m_rec   = 0;
      m_drop  = 0;
      fd_flag = 1'b0;
    end else begin
      chk("rec_count", rec_cnt, m_rec);
      chk("drop_count", drop_cnt, m_drop);
      chk("frame_done", fd, fd_flag);
      exp_ready = en && (mq.size() == 0);
      chk("tready", tready, exp_ready);
      fd_flag = 1'b0;
      if (mq.size() != 0) begin
        h = mq[0];
        if (h.drop) begin
          chk("cell_en_on_drop", cell_en, 27'd0);
          void'(mq.pop_front());
          m_drop++;
          fd_flag = h.fd;
        end else begin
          e = 27'd1 << h.id;
          chk("cell_en", cell_en, e);
          chk("cell_data", cell_data, h.pay);
          if (cell_ready[h.id]) begin
            void'(mq.pop_front());
            m_rec++;
            fd_flag = h.fd;
          end
        end
      end else begin
        chk("cell_en_idle", cell_en, 27'd0);
      end
      if (exp_ready && tvalid) begin
`ifdef MD_SCATTER_TDEST_FILTER_EN
        filt = (tdest != init_id);
`else
        filt = 1'b0;
`endif
        n = 0;
        for (int k = 0; k < 4; k++) begin
          if ((&tkeep[16*k +: 16]) && tdata[128*k + 127]) begin
            recs[n].id   = int'(tdata[128*k + 96 +: 5]);
            recs[n].pay  = tdata[128*k +: 96];
            recs[n].drop = filt || (recs[n].id >= 27);
            recs[n].fd   = 1'b0;
            n++;
          end
        end
        if (n > 0) recs[n-1].fd = tlast;
        else if (tlast) fd_flag = 1'b1;
        for (int i = 0; i < n; i++) mq.push_back(recs[i]);
      end
    end
  end

  function automatic logic [511:0] mkbeat(input logic [3:0] v, input logic [19:0] ids, input int tag);
    logic [511:0] b;
    logic [95:0]  p;
    for (int k = 0; k < 4; k++) begin
      p = {32'hBEEF0000 + 32'(tag), 32'(k), 27'd0, ids[5*k +: 5]};
      b[128*k +: 128] = {v[k], 26'h1555555, ids[5*k +: 5], p};
    end
    return b;
  endfunction

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l, input logic [15:0] dest);
    int n;
    tdata = d; tkeep = k; tlast = l; tdest = dest; tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!tready) chk("send_timeout", tready, 1'b1);
    @(posedge clk); #1;
    tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (mq.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (mq.size() != 0) chk({name, "_idle_timeout"}, mq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic expect_counts(input string name, input int r, input int d);
    @(negedge clk);
    chk({name, "_rec"}, rec_cnt, r);
    chk({name, "_drop"}, drop_cnt, d);
    @(posedge clk); #1;
  endtask

  logic [26:0] exp19 [4];

  initial begin
    exp19 = '{27'h0000001, 27'h0000020, 27'h4000000, 27'h0000008};
    rst_n = 1'b0; en = 1'b1; init_id = 16'd1; tdata = '0; tkeep = '0;
    tvalid = 1'b0; tlast = 1'b0; tdest = '0; cell_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_en", cell_en, 27'd0);
    chk("reset_fd", fd, 1'b0);
    chk("reset_rec", rec_cnt, 32'd0);
    chk("reset_drop", drop_cnt, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_reset", tready, 1'b1);
    @(posedge clk); #1;

    // Four valid lanes, every cell ready: one strobe per cycle in lane order.
    send_beat(mkbeat(4'hF, {5'd3, 5'd26, 5'd5, 5'd0}, 1), ALL, 1'b1, 16'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("r19_en", cell_en, exp19[i]);
      chk("r19_tready_low", tready, 1'b0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("r19_tready_back", tready, 1'b1);
    chk("r19_frame_done", fd, 1'b1);
    @(posedge clk); #1;
    expect_counts("r19", 4, 0);

    // Out-of-range IDs on lanes 1 and 2.
    send_beat(mkbeat(4'hF, {5'd2, 5'd31, 5'd27, 5'd1}, 2), ALL, 1'b0, 16'd0);
    @(negedge clk); chk("r20_l0", cell_en, 27'h2);
    @(negedge clk); chk("r20_l1", cell_en, 27'h0);
    @(negedge clk); chk("r20_l2", cell_en, 27'h0);
    @(negedge clk); chk("r20_l3", cell_en, 27'h4);
    @(posedge clk); #1;
    wait_idle("r20");
    expect_counts("r20", 6, 2);

    // Cell 5 stalls for six cycles; the strobe and payload must hold.
    cell_ready = ~27'h20;
    send_beat(mkbeat(4'b0011, {5'd0, 5'd0, 5'd7, 5'd5}, 3), ALL, 1'b0, 16'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("r21_hold_en", cell_en, 27'h20);
    end
    @(posedge clk); #1;
    cell_ready = '1;
    @(negedge clk); chk("r21_xfer_en", cell_en, 27'h20);
    @(negedge clk); chk("r21_next_en", cell_en, 27'h80);
    @(posedge clk); #1;
    wait_idle("r21");
    expect_counts("r21", 8, 2);

    // Lane 3 only half kept: skipped, frame ends after lane 2.
    send_beat(mkbeat(4'hF, {5'd13, 5'd12, 5'd11, 5'd10}, 4), {16'h00FF, 48'hFFFF_FFFF_FFFF}, 1'b1, 16'd0);
    @(negedge clk); chk("r22_l0", cell_en, 27'h400);
    @(negedge clk); chk("r22_l1", cell_en, 27'h800);
    @(negedge clk); chk("r22_l2", cell_en, 27'h1000);
    @(negedge clk); chk("r22_fd_pulse", fd, 1'b1); chk("r22_no_l3", cell_en, 27'h0);
    @(negedge clk); chk("r22_fd_single", fd, 1'b0);
    @(posedge clk); #1;
    expect_counts("r22", 11, 2);

    // tlast beat with no valid lane.
    send_beat(mkbeat(4'h0, 20'd0, 5), ALL, 1'b1, 16'd0);
    @(negedge clk); chk("empty_fd", fd, 1'b1); chk("empty_tready", tready, 1'b1);
    @(negedge clk); chk("empty_fd_single", fd, 1'b0);
    @(posedge clk); #1;
    expect_counts("empty", 11, 2);

    send_beat(mkbeat(4'hF, {5'd3, 5'd2, 5'd1, 5'd0}, 6), ALL, 1'b0, 16'd2);
    wait_idle("dest_miss");
`ifdef MD_SCATTER_TDEST_FILTER_EN
    expect_counts("dest_miss", 11, 6);
`else
    expect_counts("dest_miss", 15, 2);
`endif
    send_beat(mkbeat(4'hF, {5'd3, 5'd2, 5'd1, 5'd0}, 7), ALL, 1'b0, 16'd1);
    wait_idle("dest_hit");
`ifdef MD_SCATTER_TDEST_FILTER_EN
    expect_counts("dest_hit", 15, 6);
`else
    expect_counts("dest_hit", 19, 2);
`endif

    // Enable drops mid-beat: the beat completes, nothing new is taken.
    send_beat(mkbeat(4'hF, {5'd23, 5'd22, 5'd21, 5'd20}, 8), ALL, 1'b0, 16'd1);
    en = 1'b0;
    wait_idle("disable");
    tdata = mkbeat(4'hF, {5'd1, 5'd1, 5'd1, 5'd1}, 9); tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk); chk("disabled_tready", tready, 1'b0);
    end
    @(posedge clk); #1;
    tvalid = 1'b0;
`ifdef MD_SCATTER_TDEST_FILTER_EN
    expect_counts("disable", 19, 6);
`else
    expect_counts("disable", 23, 2);
`endif
    en = 1'b1;

    // Reset while the second record of a beat is on the outputs.
    send_beat(mkbeat(4'hF, {5'd3, 5'd2, 5'd1, 5'd0}, 10), ALL, 1'b0, 16'd1);
    @(negedge clk); chk("r23_first", cell_en, 27'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("r23_rec", rec_cnt, 32'd0);
    chk("r23_drop", drop_cnt, 32'd0);
    chk("r23_en", cell_en, 27'd0);
    chk("r23_tready", tready, 1'b1);
    @(posedge clk); #1;

    send_beat(mkbeat(4'b0001, {5'd0, 5'd0, 5'd0, 5'd9}, 11), ALL, 1'b1, 16'd1);
    wait_idle("recover");
    expect_counts("recover", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/h2k_particle_scatter.md
H2K_PARTICLE_SCATTER -- requirements
Module: h2k_particle_scatter

Interface
REQ-001 Parameters (name, default, meaning): AXIS_TDATA_WIDTH, 512, input beat width; STREAMING_TDEST_WIDTH, 16, tdest width; N_CELL, 27, number of cell position caches; POS_WIDTH, 96, particle record payload (3 x 32-bit).
REQ-002 Ports (name, direction, width, meaning), one clock; reset is synchronous and active-low:
- ap_clk  in  1  sole clock, all logic on rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- i_enable  in  1  level; host-to-cell init phase active.
- i_init_id  in  STREAMING_TDEST_WIDTH  destination ID accepted by this block.
- S_AXIS_h2k_tdata  in  512  four 128-bit lanes.
- S_AXIS_h2k_tkeep  in  64  byte enables.
- S_AXIS_h2k_tvalid  in  1  beat valid.
- S_AXIS_h2k_tlast  in  1  last beat of frame.
- S_AXIS_h2k_tdest  in  STREAMING_TDEST_WIDTH  beat destination.
- S_AXIS_h2k_tready  out  1  beat accepted when high with tvalid.
- o_cell_data  out  POS_WIDTH  record payload, shared by all cells.
- o_cell_en  out  N_CELL  one-hot write strobe to target cell.
- i_cell_ready  in  N_CELL  per-cell accept.
- o_frame_done  out  1  one-cycle pulse, frame fully delivered.
- o_rec_count  out  32  records delivered.
- o_drop_count  out  32  records discarded.

Function
REQ-003 Lane k (k=0..3) = tdata[128k+127:128k]: [95:0] payload, [100:96] cell ID, [126:101] ignored, [127] record-valid.
REQ-004 Lane k is pending only if tkeep[16k+15:16k] is all ones and bit [127] is 1.
REQ-005 FSM states IDLE and UNPACK; reset state IDLE.
REQ-006 S_AXIS_h2k_tready SHALL equal (state==IDLE) AND i_enable.
REQ-007 IDLE: on tvalid&tready, register tdata, pending mask, tlast; go to UNPACK if mask nonzero; else stay IDLE.
REQ-008 UNPACK: select lowest-index pending lane each cycle; output registered, first record valid the cycle after beat acceptance.
REQ-009 Selected ID < N_CELL: drive o_cell_data=payload, o_cell_en[ID]=1 (all other bits 0); hold stable until i_cell_ready[ID]=1 in that cycle, then clear lane, increment o_rec_count.
REQ-010 Selected ID >= N_CELL: clear lane in one cycle, o_cell_en all zero, increment o_drop_count.
REQ-011 When last pending lane clears, return to IDLE next cycle; at most one record transferred per cycle.
REQ-012 o_frame_done SHALL pulse one cycle on the cycle the last pending lane of a tlast beat clears; for a tlast beat with empty mask, pulse the cycle after acceptance.
REQ-013 Both counters saturate at 32'hFFFFFFFF.
REQ-014 i_enable deasserted in UNPACK: current beat finishes; no new beat accepted.
REQ-015 o_cell_en SHALL never have more than one bit set.

Reset
REQ-016 On ap_rst_n=0 at a clock edge: state=IDLE, pending mask cleared, buffered beat discarded, o_cell_en=0, o_cell_data=0, o_frame_done=0, both counters=0, tready=0 during reset.
REQ-017 Reset mid-UNPACK SHALL drop remaining lanes with no further strobes or counting.

Configuration
REQ-018 Macro MD_SCATTER_TDEST_FILTER_EN: when defined, accepted beats with tdest != i_init_id are consumed (tready unchanged), all lanes counted into o_drop_count, no cell strobe, tlast still yields o_frame_done; when undefined, tdest and i_init_id are ignored.

Verification
REQ-019 Beat with 4 valid lanes, IDs 0,5,26,3, all ready high -> o_cell_en = bit0, bit5, bit26, bit3 on cycles N+1..N+4, o_rec_count=4, tready low N+1..N+4.
REQ-020 Lane ID 27 and 31 among lanes 1,2 of a 4-lane beat -> 2 records delivered, o_drop_count=2, no strobe for lanes 1,2.
REQ-021 i_cell_ready[5]=0 for 6 cycles on record for cell 5 -> o_cell_en[5] and payload held 6 cycles, transfer on 7th, no later lane issued early.
REQ-022 tlast beat with tkeep lane 3 partial (tkeep[63:48]=16'h00FF) -> lane 3 skipped, o_frame_done single pulse after lane 2 delivered.
REQ-023 ap_rst_n low at second record of a 4-lane beat -> counters 0, o_cell_en 0 next cycle, tready high after reset release with i_enable=1.
REQ-024 With MD_SCATTER_TDEST_FILTER_EN, tdest=2, i_init_id=1, 4 valid lanes -> o_drop_count=4, no strobes; tdest=1 -> 4 records delivered.
